rtr_channel_input: RTL

RTR_CHANNEL_INPUT -- requirements
Module: rtr_channel_input

---
 rtl/rtr_pkg.sv | 31 +++
 rtl/rtr_ivc_pkt_tracker.sv | 108 ++++++++++
 rtl/rtr_channel_input.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rtr_pkg.sv
// Router channel definitions shared by the channel input and output sides:
// packet-format and reset-type constants plus channel/flit field-width helpers.
package rtr_pkg;

  localparam int PACKET_FORMAT_HEAD_TAIL       = 0;
  localparam int PACKET_FORMAT_TAIL_ONLY       = 1;
  localparam int PACKET_FORMAT_EXPLICIT_LENGTH = 2;

  localparam int RESET_TYPE_ASYNC = 0;
  localparam int RESET_TYPE_SYNC  = 1;

  function automatic int rtr_vc_idx_width(input int num_vcs);
    return (num_vcs > 1) ? $clog2(num_vcs) : 0;
  endfunction

  function automatic int rtr_flit_ctrl_width(input int packet_format);
    return (packet_format == PACKET_FORMAT_HEAD_TAIL) ? 2 : 1;
  endfunction

  function automatic int rtr_length_width(input int max_payload_length);
    return (max_payload_length > 0) ? $clog2(max_payload_length + 1) : 1;
  endfunction

  // Layout, MSB first: [link][valid][vc idx][flit ctrl][data]
  function automatic int rtr_channel_width(input int num_vcs, input int packet_format,
                                           input int enable_link_pm, input int flit_data_width);
    return ((enable_link_pm != 0) ? 1 : 0) + 1 + rtr_vc_idx_width(num_vcs)
           + rtr_flit_ctrl_width(packet_format) + flit_data_width;
  endfunction

endpackage

// File: rtl/rtr_ivc_pkt_tracker.sv
// Per-VC packet tracker: IDLE/BODY state plus remaining-length counter.
// Protocol-violation detection is built only with RTR_CHANNEL_INPUT_ERR_CHECK_EN.
module rtr_ivc_pkt_tracker
  import rtr_pkg::*;
#(
  parameter int packet_format      = PACKET_FORMAT_EXPLICIT_LENGTH,
  parameter int max_payload_length = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        flit_active,
  input  logic                                        head_in,
  input  logic                                        tail_in,
  input  logic [rtr_length_width(max_payload_length)-1:0] length_in,
  output logic                                        head_out,
  output logic                                        tail_out,
  output logic                                        error_out
);

  localparam int len_w = rtr_length_width(max_payload_length);
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BODY = 1'b1;
  localparam logic [len_w-1:0] max_len_c = len_w'(max_payload_length);
  localparam logic [len_w-1:0] one_c     = len_w'(1);
  localparam logic [len_w-1:0] zero_c    = len_w'(0);

  logic [0:0]       state_r, state_nxt_s;
  logic [len_w-1:0] cnt_r, cnt_nxt_s, len_clamped_s;
  logic             head_s, tail_s, err_s;

  // Oversized lengths are clamped so the counter never exceeds the legal maximum.
  assign len_clamped_s = (length_in > max_len_c) ? max_len_c : length_in;

  // Flit classification and next-state/counter computation for this VC.
  always_comb begin
    head_s      = 1'b0;
    tail_s      = 1'b0;
    err_s       = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (flit_active) begin
      case (packet_format)
        PACKET_FORMAT_HEAD_TAIL: begin
          head_s = head_in;
          tail_s = tail_in;
        end
        PACKET_FORMAT_TAIL_ONLY: begin
          head_s = (state_r == STATE_IDLE);
          tail_s = tail_in;
        end
        PACKET_FORMAT_EXPLICIT_LENGTH: begin
          head_s = head_in;
          if (head_in) begin
            tail_s = (length_in == zero_c);
          end else begin
            tail_s = (cnt_r == one_c);
          end
        end
        default: begin
          head_s = head_in;
          tail_s = tail_in;
        end
      endcase
      if (packet_format == PACKET_FORMAT_EXPLICIT_LENGTH) begin
        if (head_s) begin
          cnt_nxt_s = len_clamped_s;
        end else if (cnt_r != zero_c) begin
          cnt_nxt_s = cnt_r - one_c;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end else begin
        cnt_nxt_s = cnt_r;
      end
      state_nxt_s = tail_s ? STATE_IDLE : STATE_BODY;
`ifdef RTR_CHANNEL_INPUT_ERR_CHECK_EN
      err_s = (head_s && (state_r == STATE_BODY))
           || (!head_s && (state_r == STATE_IDLE) && (packet_format != PACKET_FORMAT_TAIL_ONLY))
           || ((packet_format == PACKET_FORMAT_EXPLICIT_LENGTH) && head_s && (length_in > max_len_c));
      // A stray body flit does not open a packet.
      if (!head_s && (state_r == STATE_IDLE)) begin
        state_nxt_s = STATE_IDLE;
      end else begin
        state_nxt_s = tail_s ? STATE_IDLE : STATE_BODY;
      end
`endif
    end else begin
      head_s = 1'b0;
      tail_s = 1'b0;
    end
  end

  // VC state and length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= STATE_IDLE;
      cnt_r   <= zero_c;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign head_out  = head_s;
  assign tail_out  = tail_s;
  assign error_out = err_s;

endmodule

// File: rtl/rtr_channel_input.sv
// Router channel input stage: registers the channel and recovers per-VC head/tail framing.
// RTR_CHANNEL_INPUT_ERR_CHECK_EN enables protocol-violation reporting on flit_error_out.
module rtr_channel_input
  import rtr_pkg::*;
#(
  parameter int num_vcs            = 4,
  parameter int packet_format      = PACKET_FORMAT_EXPLICIT_LENGTH,
  parameter int enable_link_pm     = 1,
  parameter int flit_data_width    = 64,
  parameter int max_payload_length = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [rtr_channel_width(num_vcs, packet_format, enable_link_pm, flit_data_width)-1:0] channel_in,
  output logic                       link_active_out,
  output logic                       flit_valid_out,
  output logic                       flit_head_out,
  output logic                       flit_tail_out,
  output logic [flit_data_width-1:0] flit_data_out,
  output logic [num_vcs-1:0]         flit_sel_out_ivc,
  output logic                       flit_error_out
);

  localparam int vc_idx_w  = rtr_vc_idx_width(num_vcs);
  localparam int vc_reg_w  = (vc_idx_w > 0) ? vc_idx_w : 1;
  localparam int ctrl_w    = rtr_flit_ctrl_width(packet_format);
  localparam int len_w     = rtr_length_width(max_payload_length);
  localparam int ctrl_lsb  = flit_data_width;
  localparam int vc_lsb    = ctrl_lsb + ctrl_w;
  localparam int valid_pos = vc_lsb + vc_idx_w;
  localparam int link_pos  = valid_pos + 1;

  logic                       link_in_s, valid_in_s, head_in_s, tail_in_s, load_s;
  logic [vc_reg_w-1:0]        vc_in_s, vc_r;
  logic                       link_r, valid_r, head_r, tail_r;
  logic [flit_data_width-1:0] data_r;
  logic [num_vcs-1:0]         sel_s, head_v_s, tail_v_s, err_v_s;

  assign valid_in_s = channel_in[valid_pos];

  if (enable_link_pm != 0) begin : g_link
    assign link_in_s = channel_in[link_pos];
    assign load_s    = link_in_s | valid_in_s;
  end else begin : g_no_link
    assign link_in_s = 1'b0;
    assign load_s    = 1'b1;
  end

  if (vc_idx_w > 0) begin : g_vc
    assign vc_in_s = channel_in[vc_lsb +: vc_reg_w];
  end else begin : g_no_vc
    assign vc_in_s = {vc_reg_w{1'b0}};
  end

  // Split the per-format control field into raw head/tail bits.
  always_comb begin
    head_in_s = 1'b0;
    tail_in_s = 1'b0;
    case (packet_format)
      PACKET_FORMAT_HEAD_TAIL: begin
        head_in_s = channel_in[ctrl_lsb + 1];
        tail_in_s = channel_in[ctrl_lsb];
      end
      PACKET_FORMAT_TAIL_ONLY: tail_in_s = channel_in[ctrl_lsb];
      default:                 head_in_s = channel_in[ctrl_lsb];
    endcase
  end

  // Valid and link bits sample every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      link_r  <= 1'b0;
    end else begin
      valid_r <= valid_in_s;
      link_r  <= link_in_s;
    end
  end

  // Control fields only load while the link is up or a flit arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vc_r   <= {vc_reg_w{1'b0}};
      head_r <= 1'b0;
      tail_r <= 1'b0;
    end else if (load_s) begin
      vc_r   <= vc_in_s;
      head_r <= head_in_s;
      tail_r <= tail_in_s;
    end
  end

  // Payload register, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load_s) begin
      data_r <= channel_in[flit_data_width-1:0];
    end
  end

  // One-hot VC select, qualified by the registered valid.
  always_comb begin
    sel_s = {num_vcs{1'b0}};
    for (int i = 0; i < num_vcs; i++) begin
      sel_s[i] = valid_r && (vc_r == vc_reg_w'(i));
    end
  end

  for (genvar gi = 0; gi < num_vcs; gi++) begin : g_ivc
    rtr_ivc_pkt_tracker #(
      .packet_format      (packet_format),
      .max_payload_length (max_payload_length)
    ) u_tracker (
      .clk         (clk),
      .reset       (reset),
      .flit_active (sel_s[gi]),
      .head_in     (head_r),
      .tail_in     (tail_r),
      .length_in   (data_r[len_w-1:0]),
      .head_out    (head_v_s[gi]),
      .tail_out    (tail_v_s[gi]),
      .error_out   (err_v_s[gi])
    );
  end

  assign flit_valid_out   = valid_r;
  assign flit_sel_out_ivc = sel_s;
  assign flit_head_out    = |head_v_s;
  assign flit_tail_out    = |tail_v_s;
  assign flit_error_out   = |err_v_s;
  assign flit_data_out    = data_r;
  assign link_active_out  = (enable_link_pm != 0) ? (link_r | valid_r) : 1'b1;

endmodule
